// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv : iterative RV32M multiply/divide unit for the EX stage.
//
// One operation at a time. A request is taken in IDLE, runs 32 iterations in
// RUN (one multiplier/divider bit per cycle), and presents its result for one
// cycle in DONE. Divide-by-zero and signed-overflow divides bypass RUN.
//
// Ports
//   clk     in   1   clock, rising edge
//   rst     in   1   asynchronous reset, active low
//   start   in   1   RV32M request from ID/EX
//   funct3  in   3   op select (MUL..REMU)
//   op_a    in  32   rs1 operand
//   op_b    in  32   rs2 operand
//   rd_in   in   5   destination register of the request
//   flush   in   1   kill the in-flight operation
//   busy    out  1   pipeline stall request
//   done    out  1   one-cycle result-valid pulse
//   result  out 32   operation result (valid while done)
//   rd_out  out  5   destination register (valid while done)
// ----------------------------------------------------------------------------
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched operation context
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [4:0]  r_cnt;
  logic        r_neg_q;    // negate product / quotient
  logic        r_neg_r;    // negate remainder
  logic [31:0] r_result;

  // Multiplier datapath
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;

  // Divider datapath
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_div;

  // Request decode
  logic        w_accept;
  logic        w_is_div;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_fast;
  logic [31:0] w_fast_res;

  // Iteration step
  logic [63:0] w_acc_nxt;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quot_nxt;
  logic [63:0] w_prod_fin;
  logic [31:0] w_quot_fin;
  logic [31:0] w_rem_fin;
  logic [31:0] w_final;

  assign w_accept   = (r_state == ST_IDLE) && start && !flush;
  assign w_is_div   = funct3[2];
  // MUL keeps only the low word, which is sign-independent, so it runs unsigned.
  assign w_a_signed = w_is_div ? !funct3[0] : ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10));
  assign w_b_signed = w_is_div ? !funct3[0] : (funct3[1:0] == 2'b01);
  assign w_a_neg    = w_a_signed && op_a[31];
  assign w_b_neg    = w_b_signed && op_b[31];
  assign w_a_mag    = w_a_neg ? (~op_a + 32'd1) : op_a;
  assign w_b_mag    = w_b_neg ? (~op_b + 32'd1) : op_b;
  assign w_div_zero = w_is_div && (op_b == 32'd0);
  assign w_ovf      = w_is_div && !funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign w_fast     = w_div_zero || w_ovf;

  // Result for the cases that bypass the iterative datapath
  always_comb begin
    w_fast_res = 32'd0;
    if (w_div_zero) begin
      w_fast_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
    end else begin
      w_fast_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One shift-add step and one restoring-division step, computed in parallel
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
  assign w_shift    = {r_rem, r_quot[31]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_ge       = !w_diff[32];
  assign w_rem_nxt  = w_ge ? w_diff[31:0] : w_shift[31:0];
  assign w_quot_nxt = {r_quot[30:0], w_ge};

  assign w_prod_fin = r_neg_q ? (~w_acc_nxt + 64'd1) : w_acc_nxt;
  assign w_quot_fin = r_neg_q ? (~w_quot_nxt + 32'd1) : w_quot_nxt;
  assign w_rem_fin  = r_neg_r ? (~w_rem_nxt + 32'd1) : w_rem_nxt;

  // Final result select from the last iteration's values
  always_comb begin
    w_final = 32'd0;
    case (r_funct3)
      3'b000:                 w_final = w_prod_fin[31:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_fin[63:32];
      3'b100, 3'b101:         w_final = w_quot_fin;
      default:                w_final = w_rem_fin;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_fast ? ST_DONE : ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == 5'd31) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; busy must be combinational so the accept cycle stalls too
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_IDLE: busy = start && !flush;
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand latch, iteration and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_funct3 <= 3'd0;
      r_rd     <= 5'd0;
      r_cnt    <= 5'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= 32'd0;
      r_acc    <= 64'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_rem    <= 32'd0;
      r_quot   <= 32'd0;
      r_div    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_funct3 <= funct3;
            r_rd     <= rd_in;
            r_cnt    <= 5'd0;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_acc    <= 64'd0;
            r_mcand  <= {32'd0, w_a_mag};
            r_mplier <= w_b_mag;
            r_rem    <= 32'd0;
            r_quot   <= w_a_mag;
            r_div    <= w_b_mag;
            if (w_fast) begin
              r_result <= w_fast_res;
            end
          end
        end
        ST_RUN: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= {r_mcand[62:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[31:1]};
          r_rem    <= w_rem_nxt;
          r_quot   <= w_quot_nxt;
          r_cnt    <= r_cnt + 5'd1;
          if (!flush && (r_cnt == 5'd31)) begin
            r_result <= w_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign rd_out = r_rd;

endmodule

// File: tb/tb_ex_muldiv.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv : directed self-checking bench for ex_muldiv.
// Cycle 0 is the cycle in which start is presented; outputs are sampled on
// the falling edge, so "cycle k" is the k-th falling edge after the accept.
// ----------------------------------------------------------------------------
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ex_muldiv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op at the next falling edge and check latency, result and rd.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                        input bit hold, input string name);
    int cyc;
    int busy_cnt;
    bit seen;
    bit busy_at_done;
    logic [31:0] res_at_done;
    logic [4:0]  rd_at_done;
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; flush = 1'b0; start = 1'b1;
    #1;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL %s busy_accept: got %b want 1", name, busy);
    else pass_cnt++;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    // Scramble inputs to prove the operands were latched
    op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0003; funct3 = ~f3; rd_in = ~rd;
    cyc = 0; busy_cnt = 0; seen = 1'b0; busy_at_done = 1'b0;
    res_at_done = 32'd0; rd_at_done = 5'd0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        seen = 1'b1;
        busy_at_done = busy;
        res_at_done = result;
        rd_at_done = rd_out;
      end else if (busy === 1'b1) begin
        busy_cnt++;
      end
    end
    total_cnt++;
    if (!seen) $display("FAIL %s done_timeout: no done within %0d cycles", name, cyc);
    else pass_cnt++;
    if (seen) begin
      total_cnt++;
      if (cyc != exp_lat) $display("FAIL %s latency: got cycle %0d want %0d", name, cyc, exp_lat);
      else pass_cnt++;
      total_cnt++;
      if (res_at_done !== exp_res) $display("FAIL %s result: got %h want %h", name, res_at_done, exp_res);
      else pass_cnt++;
      total_cnt++;
      if (rd_at_done !== rd) $display("FAIL %s rd_out: got %0d want %0d", name, rd_at_done, rd);
      else pass_cnt++;
      total_cnt++;
      if (busy_cnt != exp_lat - 1 || busy_at_done !== 1'b0)
        $display("FAIL %s busy_window: got %0d busy cycles (busy at done %b) want %0d (0)",
                 name, busy_cnt, busy_at_done, exp_lat - 1);
      else pass_cnt++;
    end
    // Cycle after DONE: back in IDLE, not re-accepted even if start was held
    @(negedge clk);
    start = 1'b0;
    #1;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if (result !== 32'd0 || rd_out !== 5'd0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_outputs: got result=%h rd=%0d done=%b busy=%b want 0 0 0 0",
               result, rd_out, done, busy);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mul();
    run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB, 33, 1'b0, "mul_7xm3");
    run_op(3'b001, 32'h8000_0000,  32'h8000_0000, 5'd3,  32'h4000_0000, 33, 1'b0, "mulh_min");
    run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33, 1'b0, "mulhu_max");
    run_op(3'b010, 32'hFFFF_FFFF,  32'd2,         5'd5,  32'hFFFF_FFFF, 33, 1'b0, "mulhsu_m1x2");
    run_op(3'b011, 32'h0001_0000,  32'h0001_0000, 5'd6,  32'h0000_0001, 33, 1'b0, "mulhu_2p32");
  endtask

  task automatic test_div();
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 33, 1'b0, "div_m7d2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 33, 1'b0, "rem_m7d2");
    run_op(3'b101, 32'd100,       32'd7,         5'd9,  32'd14,        33, 1'b0, "divu_100d7");
    run_op(3'b111, 32'd100,       32'd7,         5'd10, 32'd2,         33, 1'b0, "remu_100d7");
    run_op(3'b100, 32'd20,        32'hFFFF_FFFD, 5'd12, 32'hFFFF_FFFA, 33, 1'b0, "div_20dm3");
    run_op(3'b110, 32'd20,        32'hFFFF_FFFD, 5'd13, 32'd2,         33, 1'b0, "rem_20dm3");
  endtask

  task automatic test_div_special();
    run_op(3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1, 1'b0, "divu_by0");
    run_op(3'b110, 32'd7,         32'd0,         5'd15, 32'd7,         1, 1'b0, "rem_by0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, 1'b0, "div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1, 1'b0, "rem_ovf");
  endtask

  task automatic test_flush();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd18; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    flush = 1'b1;                       // cycle 10 of RUN
    @(negedge clk);                     // cycle 11
    #1;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || done_seen != 0)
      $display("FAIL flush_abort: got busy=%b done=%b early_done=%0d want 0 0 0", busy, done, done_seen);
    else pass_cnt++;
    flush = 1'b0;
    // New start in cycle 12, held through DONE
    run_op(3'b000, 32'd6, 32'd9, 5'd19, 32'd54, 33, 1'b1, "mul_after_flush_hold");
  endtask

  task automatic test_reset_mid_run();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd10; op_b = 32'd10; rd_in = 5'd20; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 15; c++) @(negedge clk);
    rst = 1'b0;                         // cycle 15 of RUN
    #1;
    total_cnt++;
    if (result !== 32'd0 || rd_out !== 5'd0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_mid_run: got result=%h rd=%0d done=%b busy=%b want 0 0 0 0",
               result, rd_out, done, busy);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    total_cnt++;
    if (done_seen != 0) $display("FAIL reset_no_done: got %0d done pulses want 0", done_seen);
    else pass_cnt++;
    run_op(3'b000, 32'd12, 32'd13, 5'd21, 32'd156, 33, 1'b0, "mul_after_reset");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_flush();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
